// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding,
// byte-lane indices and word geometry.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

endpackage

// File: rtl/loader_word_assembler.sv
// Datapath of the loader: collects payload bytes into little-endian words,
// keeps the running XOR checksum, counts words and issues one write strobe
// the cycle after each word's fourth byte.
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_complete,
    output logic [7:0]  checksum,
    output logic [15:0] word_count,
    output logic        mem_write,
    output logic [31:0] wr_address,
    output logic [31:0] wr_data
);

    logic [1:0]  lane_reg;
    logic [7:0]  lane_byte_reg [0:WORD_BYTES-2];
    logic [7:0]  checksum_reg;
    logic [15:0] word_count_reg;
    logic        mem_write_reg;
    logic [31:0] wr_address_reg;
    logic [31:0] wr_data_reg;

    // The fourth byte goes straight into the write word, so only lanes 0..2 are stored.
    assign word_complete = byte_en && (lane_reg == LANE_3);

    // Lane counter and running checksum; both restart when a new frame begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_reg     <= LANE_0;
            checksum_reg <= 8'd0;
        end else if (clear) begin
            lane_reg     <= LANE_0;
            checksum_reg <= 8'd0;
        end else if (byte_en) begin
            lane_reg     <= lane_reg + 2'd1;
            checksum_reg <= checksum_reg ^ byte_data;
        end
    end

    // One holding register per lower byte lane, loaded when its lane is current.
    for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
        // Capture the byte arriving on lane gi.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lane_byte_reg[gi] <= 8'd0;
            end else if (byte_en && (lane_reg == 2'(gi))) begin
                lane_byte_reg[gi] <= byte_data;
            end
        end
    end

    // Write strobe, address/data and word counter all update on the edge that takes the 4th byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_write_reg  <= 1'b0;
            wr_address_reg <= 32'd0;
            wr_data_reg    <= 32'd0;
            word_count_reg <= 16'd0;
        end else begin
            mem_write_reg <= word_complete;
            if (clear) begin
                word_count_reg <= 16'd0;
            end else if (word_complete) begin
                wr_address_reg <= {14'd0, word_count_reg, 2'b00};
                wr_data_reg    <= {byte_data, lane_byte_reg[2], lane_byte_reg[1], lane_byte_reg[0]};
                word_count_reg <= word_count_reg + 16'd1;
            end
        end
    end

    assign checksum   = checksum_reg;
    assign word_count = word_count_reg;
    assign mem_write  = mem_write_reg;
    assign wr_address = wr_address_reg;
    assign wr_data    = wr_data_reg;

endmodule

// File: rtl/program_loader.sv
// Program memory writer: parses a length/payload/checksum frame from the host
// byte link, writes the payload words from address 0 and keeps the core in
// reset until a frame has loaded with a matching checksum.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PROGRAM_MEMORY_DEPTH = 64,
    parameter int CNT_WIDTH = $clog2(PROGRAM_MEMORY_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Start_i,
    input  logic [7:0]           Byte_Data_i,
    input  logic                 Byte_Valid_i,
    output logic                 Byte_Ready_o,
    output logic                 Mem_Write_o,
    output logic [31:0]          Wr_Address_o,
    output logic [31:0]          Wr_Data_o,
    output logic                 Core_Reset_o,
    output logic                 Busy_o,
    output logic                 Done_o,
    output logic                 Error_o,
    output logic [CNT_WIDTH-1:0] Words_Loaded_o
);

    loader_state_t state_reg, state_next;
    logic [15:0]   len_reg;
    logic [15:0]   len_full;
    logic          byte_fire;
    logic          start_accept;
    logic          payload_en;
    logic          word_complete;
    logic          last_word;
    logic [7:0]    checksum;
    logic [15:0]   word_count;
    logic          ready_reg, busy_reg, done_reg, error_reg, core_reset_reg;

    assign byte_fire    = Byte_Valid_i && ready_reg;
    assign start_accept = Start_i && (state_reg == IDLE || state_reg == DONE || state_reg == ERROR);
    assign payload_en   = byte_fire && (state_reg == DATA);
    assign len_full     = {Byte_Data_i, len_reg[7:0]};
    // word_count equals the index of the word being completed; len_reg is nonzero in DATA.
    assign last_word    = word_complete && (word_count == len_reg - 16'd1);

    loader_word_assembler u_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_accept),
        .byte_en       (payload_en),
        .byte_data     (Byte_Data_i),
        .word_complete (word_complete),
        .checksum      (checksum),
        .word_count    (word_count),
        .mem_write     (Mem_Write_o),
        .wr_address    (Wr_Address_o),
        .wr_data       (Wr_Data_o)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame sequencing: length, payload, checksum, then a sticky result state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERROR: if (Start_i) state_next = LEN_LO;
            LEN_LO:            if (byte_fire) state_next = LEN_HI;
            LEN_HI: begin
                if (byte_fire) begin
                    if (len_full > 16'(PROGRAM_MEMORY_DEPTH)) state_next = ERROR;
                    else if (len_full == 16'd0)              state_next = CHECK;
                    else                                     state_next = DATA;
                end
            end
            DATA:              if (last_word) state_next = CHECK;
            CHECK: begin
                if (byte_fire) state_next = (Byte_Data_i == checksum) ? DONE : ERROR;
            end
            default:           state_next = IDLE;
        endcase
    end

    // Word count N, captured one byte at a time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg <= 16'd0;
        end else if (byte_fire && state_reg == LEN_LO) begin
            len_reg[7:0] <= Byte_Data_i;
        end else if (byte_fire && state_reg == LEN_HI) begin
            len_reg[15:8] <= Byte_Data_i;
        end
    end

    // Status outputs registered from the next state so they track state_reg exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            core_reset_reg <= 1'b1;
        end else begin
            ready_reg      <= (state_next inside {LEN_LO, LEN_HI, DATA, CHECK});
            busy_reg       <= (state_next inside {LEN_LO, LEN_HI, DATA, CHECK});
            done_reg       <= (state_next == DONE);
            error_reg      <= (state_next == ERROR);
            core_reset_reg <= (state_next != DONE);
        end
    end

    assign Byte_Ready_o   = ready_reg;
    assign Busy_o         = busy_reg;
    assign Done_o         = done_reg;
    assign Error_o        = error_reg;
    assign Core_Reset_o   = core_reset_reg;
    assign Words_Loaded_o = word_count[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frame stimulus pushes expected writes,
// a negedge monitor pops and compares every Mem_Write_o pulse.
module tb_program_loader;

    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          Start_i;
    logic [7:0]    Byte_Data_i;
    logic          Byte_Valid_i;
    logic          Byte_Ready_o;
    logic          Mem_Write_o;
    logic [31:0]   Wr_Address_o;
    logic [31:0]   Wr_Data_o;
    logic          Core_Reset_o;
    logic          Busy_o;
    logic          Done_o;
    logic          Error_o;
    logic [CW-1:0] Words_Loaded_o;

    int checks = 0;
    int passed = 0;
    int write_count = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] fw [0:DEPTH-1];

    program_loader #(.PROGRAM_MEMORY_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .Start_i        (Start_i),
        .Byte_Data_i    (Byte_Data_i),
        .Byte_Valid_i   (Byte_Valid_i),
        .Byte_Ready_o   (Byte_Ready_o),
        .Mem_Write_o    (Mem_Write_o),
        .Wr_Address_o   (Wr_Address_o),
        .Wr_Data_o      (Wr_Data_o),
        .Core_Reset_o   (Core_Reset_o),
        .Busy_o         (Busy_o),
        .Done_o         (Done_o),
        .Error_o        (Error_o),
        .Words_Loaded_o (Words_Loaded_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b0 && Mem_Write_o === 1'b1) begin
            write_count++;
            if (exp_addr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                         Wr_Address_o, Wr_Data_o);
            end else begin
                logic [31:0] a, d;
                a = exp_addr_q.pop_front();
                d = exp_data_q.pop_front();
                check("wr_address", Wr_Address_o, a);
                check("wr_data", Wr_Data_o, d);
                check("words_loaded_at_write", 32'(Words_Loaded_o), (a >> 2) + 32'd1);
                $display("write addr=0x%08h data=0x%08h", Wr_Address_o, Wr_Data_o);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                Byte_Valid_i = 1'b0;
            end
        end
        @(negedge clk);
        Byte_Data_i  = b;
        Byte_Valid_i = 1'b1;
        n = 0;
        while (!Byte_Ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!Byte_Ready_o) begin
            checks++;
            $display("FAIL byte_ready_timeout: got ready=0 for byte 0x%02h, expected ready=1", b);
        end
        @(posedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        Byte_Valid_i = 1'b0;
        Start_i      = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
        check("busy_after_start", Busy_o, 1);
        check("done_cleared", Done_o, 0);
        check("error_cleared", Error_o, 0);
        check("words_cleared", 32'(Words_Loaded_o), 0);
    endtask

    // Sends a frame of n words from fw[]; stop_after >= 0 abandons after that many payload bytes.
    task automatic load_frame(input int n, input int stop_after, input logic [7:0] flip,
                              input bit gaps, input int mid_start_at);
        logic [7:0] cs;
        logic [7:0] b;
        logic [31:0] w32;
        int wc_start;
        cs = 8'd0;
        wc_start = write_count;
        do_start();
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        for (int w = 0; w < n; w++) begin
            for (int l = 0; l < 4; l++) begin
                if (stop_after >= 0 && w * 4 + l == stop_after) return;
                if (w * 4 + l == mid_start_at) begin
                    @(negedge clk);
                    Byte_Valid_i = 1'b0;
                    Start_i      = 1'b1;
                    @(negedge clk);
                    Start_i = 1'b0;
                    check("start_ignored_busy", Busy_o, 1);
                    check("start_ignored_ready", Byte_Ready_o, 1);
                end
                w32 = fw[w];
                b   = w32[8*l +: 8];
                cs  = cs ^ b;
                send_byte(b, gaps);
                if (l == 3) begin
                    exp_addr_q.push_back(32'(w * 4));
                    exp_data_q.push_back(fw[w]);
                end
            end
        end
        @(negedge clk);
        Byte_Valid_i = 1'b0;
        check("core_reset_before_checksum", Core_Reset_o, 1);
        send_byte(cs ^ flip, 1'b0);
        @(negedge clk);
        Byte_Valid_i = 1'b0;
        check("core_reset_after_checksum", Core_Reset_o, (flip != 8'd0) ? 1 : 0);
        check("done", Done_o, (flip == 8'd0) ? 1 : 0);
        check("error", Error_o, (flip != 8'd0) ? 1 : 0);
        check("busy_end", Busy_o, 0);
        check("ready_end", Byte_Ready_o, 0);
        check("words_loaded", 32'(Words_Loaded_o), 32'(n));
        check("write_count", 32'(write_count - wc_start), 32'(n));
        check("scoreboard_empty", 32'(exp_addr_q.size()), 0);
        $display("frame n=%0d flip=0x%02h done=%0b error=%0b words=%0d", n, flip, Done_o, Error_o, Words_Loaded_o);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish within time budget");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int wc;
        reset        = 1'b1;
        Start_i      = 1'b0;
        Byte_Data_i  = 8'd0;
        Byte_Valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_core_reset", Core_Reset_o, 1);
        check("rst_ready", Byte_Ready_o, 0);
        check("rst_mem_write", Mem_Write_o, 0);
        check("rst_busy", Busy_o, 0);
        check("rst_done", Done_o, 0);
        check("rst_error", Error_o, 0);
        check("rst_addr", Wr_Address_o, 0);
        check("rst_data", Wr_Data_o, 0);
        check("rst_words", 32'(Words_Loaded_o), 0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word frame, good checksum, then same frame with corrupted checksum.
        fw[0] = 32'h00500093;
        fw[1] = 32'h00A08113;
        load_frame(2, -1, 8'h00, 1'b0, -1);
        load_frame(2, -1, 8'h01, 1'b0, -1);

        // Oversize length: rejected right after LEN_HI with no writes.
        wc = write_count;
        do_start();
        send_byte(8'd65, 1'b0);
        send_byte(8'd0, 1'b0);
        @(negedge clk);
        Byte_Valid_i = 1'b0;
        check("oversize_error", Error_o, 1);
        check("oversize_ready", Byte_Ready_o, 0);
        check("oversize_core_reset", Core_Reset_o, 1);
        repeat (3) @(negedge clk);
        check("oversize_ready_later", Byte_Ready_o, 0);
        check("oversize_writes", 32'(write_count - wc), 0);
        $display("frame n=65 error=%0b", Error_o);

        // Empty frame.
        load_frame(0, -1, 8'h00, 1'b0, -1);

        // Four-word frame with random valid gaps and an ignored mid-frame start.
        fw[0] = 32'h00100093;
        fw[1] = 32'h00200113;
        fw[2] = 32'h002081B3;
        fw[3] = 32'h0000006F;
        load_frame(4, -1, 8'h00, 1'b1, 6);

        // Full-depth frame: last address 4*(DEPTH-1).
        for (int i = 0; i < DEPTH; i++)
            fw[i] = {8'(i), 8'hA5, 8'(i * 3), ~8'(i)};
        load_frame(DEPTH, -1, 8'h00, 1'b0, -1);

        // Reset after 5 payload bytes of a 3-word frame.
        fw[0] = 32'hDEADBEEF;
        fw[1] = 32'h12345678;
        fw[2] = 32'hCAFEF00D;
        load_frame(3, 5, 8'h00, 1'b0, -1);
        @(negedge clk);
        reset        = 1'b1;
        Byte_Valid_i = 1'b0;
        #1;
        check("midrst_core_reset", Core_Reset_o, 1);
        check("midrst_ready", Byte_Ready_o, 0);
        check("midrst_busy", Busy_o, 0);
        check("midrst_done", Done_o, 0);
        check("midrst_mem_write", Mem_Write_o, 0);
        check("midrst_addr", Wr_Address_o, 0);
        check("midrst_data", Wr_Data_o, 0);
        check("midrst_words", 32'(Words_Loaded_o), 0);
        check("midrst_scoreboard", 32'(exp_addr_q.size()), 0);
        @(negedge clk);
        reset = 1'b0;
        fw[0] = 32'h01234567;
        fw[1] = 32'h89ABCDEF;
        fw[2] = 32'h0F1E2D3C;
        load_frame(3, -1, 8'h00, 1'b0, -1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
